// File: rtl/top_calling_pkg.sv
// top_calling_pkg
//   Shared definitions for the dual-channel offset unit: datapath width,
//   default per-channel offsets and the adder overflow-mode enumeration.
package top_calling_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] DEFAULT_OFFSET_A = 8'h10;
    localparam logic [DATA_W-1:0] DEFAULT_OFFSET_B = 8'h20;

    // WRAP: result is the sum modulo 2^DATA_W.
    // SAT : result clamps to all-ones when the sum carries out.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage

// File: rtl/offset_adder.sv
// offset_adder
//   Registered constant-offset adder with selectable overflow handling.
//   Ports:
//     clk    in   system clock, rising-edge active
//     Reset  in   asynchronous active-low reset, clears result and ovf
//     a      in   DATA_W-bit operand, sampled every rising edge
//     result out  registered (a + OFFSET), wrapped or saturated per MODE
//     ovf    out  registered carry-out (WRAP) / saturation flag (SAT)
module offset_adder
    import top_calling_pkg::*;
#(
    parameter logic [DATA_W-1:0] OFFSET = '0,
    parameter mode_e             MODE   = MODE_WRAP
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] result_d, result_q;
    logic              ovf_d, ovf_q;

    assign sum = {1'b0, a} + {1'b0, OFFSET};

    always_comb begin
        result_d = sum[DATA_W-1:0];
        ovf_d    = sum[DATA_W];
        // A sum landing exactly on all-ones has no carry, so it is not
        // treated as saturation.
        if (MODE == MODE_SAT && sum[DATA_W]) begin
            result_d = '1;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: rtl/top_calling_core.sv
// top_calling_core
//   Dual-channel registered offset unit. Channel A adds OFFSET_A and wraps
//   modulo 256; channel B adds OFFSET_B and saturates at 8'hFF. Each
//   channel owns its constant as an instance parameter.
//   Ports:
//     clk      in   system clock, rising-edge active
//     Reset    in   asynchronous active-low reset, clears all outputs
//     a        in   8-bit operand (typically from a free-running counter)
//     result_a out  registered (a + OFFSET_A) mod 256
//     result_b out  registered min(a + OFFSET_B, 8'hFF)
//     ovf_a    out  registered carry-out of channel A
//     ovf_b    out  registered saturation flag of channel B
module top_calling_core
    import top_calling_pkg::*;
#(
    parameter logic [DATA_W-1:0] OFFSET_A = DEFAULT_OFFSET_A,
    parameter logic [DATA_W-1:0] OFFSET_B = DEFAULT_OFFSET_B
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] result_a,
    output logic [DATA_W-1:0] result_b,
    output logic              ovf_a,
    output logic              ovf_b
);

    offset_adder #(
        .OFFSET (OFFSET_A),
        .MODE   (MODE_WRAP)
    ) u_chan_a (
        .clk    (clk),
        .Reset  (Reset),
        .a      (a),
        .result (result_a),
        .ovf    (ovf_a)
    );

    offset_adder #(
        .OFFSET (OFFSET_B),
        .MODE   (MODE_SAT)
    ) u_chan_b (
        .clk    (clk),
        .Reset  (Reset),
        .a      (a),
        .result (result_b),
        .ovf    (ovf_b)
    );

endmodule

// File: tb/tb_top_calling_core.sv
module tb_top_calling_core;

    logic       clk;
    logic       Reset;
    logic [7:0] a;
    logic [7:0] result_a, result_b;
    logic       ovf_a, ovf_b;
    logic [7:0] result_a2, result_b2;
    logic       ovf_a2, ovf_b2;

    int checks = 0;
    int errors = 0;

    top_calling_core dut (
        .clk      (clk),
        .Reset    (Reset),
        .a        (a),
        .result_a (result_a),
        .result_b (result_b),
        .ovf_a    (ovf_a),
        .ovf_b    (ovf_b)
    );

    top_calling_core #(
        .OFFSET_A (8'h00),
        .OFFSET_B (8'hFF)
    ) dut2 (
        .clk      (clk),
        .Reset    (Reset),
        .a        (a),
        .result_a (result_a2),
        .result_b (result_b2),
        .ovf_a    (ovf_a2),
        .ovf_b    (ovf_b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       oa;
        logic       ob;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ra, input logic [7:0] rb,
                           input logic oa, input logic ob);
        chk({tag, ".result_a"}, result_a, ra);
        chk({tag, ".result_b"}, result_b, rb);
        chk({tag, ".ovf_a"}, {7'd0, ovf_a}, {7'd0, oa});
        chk({tag, ".ovf_b"}, {7'd0, ovf_b}, {7'd0, ob});
    endtask

    // Apply operand, take one rising edge, sample 1 time unit later.
    task automatic step(input logic [7:0] val);
        a = val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned exp_b;

        // a, result_a, result_b, ovf_a, ovf_b  (OFFSET_A=10, OFFSET_B=20)
        vecs[0] = '{8'h00, 8'h10, 8'h20, 1'b0, 1'b0};
        vecs[1] = '{8'hEF, 8'hFF, 8'hFF, 1'b0, 1'b1};
        vecs[2] = '{8'hF0, 8'h00, 8'hFF, 1'b1, 1'b1};
        vecs[3] = '{8'hDF, 8'hEF, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'hE0, 8'hF0, 8'hFF, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 8'h0F, 8'hFF, 1'b1, 1'b1};
        vecs[6] = '{8'h7F, 8'h8F, 8'h9F, 1'b0, 1'b0};
        vecs[7] = '{8'h01, 8'h11, 8'h21, 1'b0, 1'b0};

        // Reset held low across clock edges with a nonzero operand.
        Reset = 1'b0;
        a     = 8'h37;
        #12;
        chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        Reset = 1'b1;
        step(8'h00);
        chk_all("first_after_reset", 8'h10, 8'h20, 1'b0, 1'b0);

        // Table-driven boundary and pattern vectors.
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].a);
            chk_all($sformatf("vec%0d", i), vecs[i].ra, vecs[i].rb, vecs[i].oa, vecs[i].ob);
        end

        // Parameter independence on the second instance.
        step(8'h01);
        chk("indep.result_a", result_a2, 8'h01);
        chk("indep.ovf_a", {7'd0, ovf_a2}, 8'h00);
        chk("indep.result_b", result_b2, 8'hFF);
        chk("indep.ovf_b", {7'd0, ovf_b2}, 8'h01);
        step(8'h00);
        chk("indep0.result_b", result_b2, 8'hFF);
        chk("indep0.ovf_b", {7'd0, ovf_b2}, 8'h00);
        chk("indep0.result_a", result_a2, 8'h00);

        // Counter sweep 0..255.
        for (int i = 0; i < 256; i++) begin
            step(i[7:0]);
            exp_b = (i + 32 > 255) ? 255 : i + 32;
            chk_all($sformatf("sweep%0d", i), 8'((i + 16) % 256), exp_b[7:0],
                    (i + 16) > 255, (i + 32) > 255);
        end

        // Mid-stream asynchronous reset.
        step(8'h80);
        chk_all("pre_midreset", 8'h90, 8'hA0, 1'b0, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        chk_all("midreset_async", 8'h00, 8'h00, 1'b0, 1'b0);
        a = 8'h42;
        @(posedge clk);
        #1;
        chk_all("midreset_held", 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        chk_all("release_no_edge", 8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h42);
        chk_all("release_reload", 8'h52, 8'h62, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/top_calling_core.md
# top_calling_core

Dual-channel registered offset unit: each clock it adds a per-channel constant to the 8-bit input `a`. Channel A wraps modulo 256; channel B saturates at 8'hFF. Each channel carries its own constant as a local instance parameter, so the two channels never share a global value. It sits downstream of an 8-bit free-running counter, which drives `a`, and feeds both results to consumer logic.

## Interface
- `OFFSET_A`, default 8'h10: constant added on channel A.
- `OFFSET_B`, default 8'h20: constant added on channel B.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `Reset`  input  1  asynchronous, active-low reset. The block is in reset while `Reset`=0.
- `a`  input  8  operand, sampled every rising `clk`.
- `result_a`  output  8  registered `(a + OFFSET_A) mod 256`.
- `result_b`  output  8  registered `min(a + OFFSET_B, 8'hFF)`.
- `ovf_a`  output  1  registered; 1 when the channel-A sum carried out of bit 7.
- `ovf_b`  output  1  registered; 1 when channel B saturated.
- One clock domain only; the block has no enable and no handshake.

## Operation
- Each channel computes a 9-bit sum `{1'b0,a} + {1'b0,OFFSET}`.
- Channel A (wrap mode):
  - result = sum[7:0]
  - ovf = sum[8]
- Channel B (saturate mode):
  - if sum[8]=1: result = 8'hFF, ovf = 1
  - else: result = sum[7:0], ovf = 0
- A sum of exactly 8'hFF is not saturation, so ovf_b = 0.
- Channels are fully independent; changing one parameter must not affect the other channel.
- OFFSET = 0: result equals `a` delayed one cycle and ovf is always 0, in both modes.
- Any value of `a` is legal, including X-free wrap from 8'hFF to 8'h00 driven by the upstream counter.

## Timing
- Reset: while `Reset`=0, all four outputs are forced to 0 immediately, with no clock required.
- Reset release: the first rising `clk` after `Reset` returns to 1 loads valid results.
- Latency: exactly 1 cycle. Outputs at edge N+1 reflect the `a` sampled at edge N.
- Throughput: a new operand is accepted every cycle.
- Reset asserted mid-stream:
  - outputs clear asynchronously;
  - the in-flight result is discarded and not replayed after release.
- No combinational path from `a` to any output; all outputs come straight from flops.

## Structure
- Shared package `top_calling_pkg`:
  - `DATA_W` = 8
  - `DEFAULT_OFFSET_A` = 8'h10
  - `DEFAULT_OFFSET_B` = 8'h20
  - mode enumeration `MODE_WRAP` / `MODE_SAT`
- Sub-module `offset_adder`:
  - parameters `OFFSET` and `MODE`
  - ports `clk`, `Reset`, `a`, `result`, `ovf`
  - contains the 9-bit adder, saturation mux and output flops
- `top_calling_core` instantiates `offset_adder` twice:
  - channel A with `MODE_WRAP`
  - channel B with `MODE_SAT`
- The offset constants live only as instance parameters. No global text macros are used.

## Test plan
- Reset: hold `Reset`=0 for 14 time units while `clk` toggles and `a`=8'h37 → all outputs 0. Release, then one edge with `a`=8'h00 → result_a=8'h10, result_b=8'h20, ovf_a=0, ovf_b=0.
- Counter sweep: drive `a`=0..255 from a counter → each cycle result_a equals previous `a`+8'h10 mod 256 and result_b equals previous `a`+8'h20 clamped to 8'hFF.
- Wrap boundary:
  - `a`=8'hEF → result_a=8'hFF, ovf_a=0.
  - `a`=8'hF0 → result_a=8'h00, ovf_a=1.
- Saturate boundary:
  - `a`=8'hDF → result_b=8'hFF, ovf_b=0.
  - `a`=8'hE0 → result_b=8'hFF, ovf_b=1.
  - `a`=8'hFF → result_b=8'hFF, ovf_b=1.
- Mid-stream reset: pull `Reset` low between edges while `a`=8'h80 → outputs drop to 0 before the next edge. Release → first edge reloads from the current `a`.
- Parameter independence: OFFSET_A=8'h00, OFFSET_B=8'hFF, `a`=8'h01 → result_a=8'h01, ovf_a=0, result_b=8'hFF, ovf_b=1.
